ibex_data_bus_bridge: RTL and testbench

//  Bridge between the ibex_core data port and its two targets: the sky130 1 KB SRAM macro (data memory)
//  and a fabric-mapped peripheral window reached over eFPGA UIO signals. Generates proper gnt/rvalid/err
//  per transaction (replaces the tied-high data rvalid). One transaction in the fabric path; SRAM pipelined.

---
 rtl/ibex_bridge_pkg.sv | 28 ++
 rtl/ibex_bridge_decode.sv | 40 ++++
 rtl/ibex_data_bus_bridge.sv | 154 +++++++++++++++
 tb/tb_ibex_data_bus_bridge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ibex_bridge_pkg.sv
// ============================================================================
// Module  : ibex_bridge_pkg
// Purpose : Shared types and constants for the ibex data-bus bridge.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package ibex_bridge_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SRAM_RESP = 3'd1;
  localparam state_t ST_FAB_WAIT  = 3'd2;
  localparam state_t ST_FAB_RESP  = 3'd3;
  localparam state_t ST_ERR_RESP  = 3'd4;

  typedef enum logic [1:0] {
    REG_SRAM = 2'd0,
    REG_FAB  = 2'd1,
    REG_NONE = 2'd2
  } region_e;

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

`default_nettype wire

// File: rtl/ibex_bridge_decode.sv
// ============================================================================
// Module  : ibex_bridge_decode
// Purpose : Byte address -> target region plus per-target word address.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ibex_bridge_decode
  import ibex_bridge_pkg::*;
#(
  parameter int          SRAM_AW   = 8,
  parameter logic [31:0] SRAM_BASE = 32'h0000_0000,
  parameter int          FAB_AW    = 12,
  parameter logic [31:0] FAB_BASE  = 32'h1000_0000
) (
  input  logic [31:0]        i_addr,
  output region_e            o_region,
  output logic [SRAM_AW-1:0] o_sram_waddr,
  output logic [FAB_AW-1:0]  o_fab_waddr
);

  // Byte offset is ignored: the core only issues word-aligned accesses.
  logic w_unused_byte_ofs;
  assign w_unused_byte_ofs = ^i_addr[1:0];

  assign o_sram_waddr = i_addr[SRAM_AW+1:2];
  assign o_fab_waddr  = i_addr[FAB_AW+1:2];

  always_comb begin
    o_region = REG_NONE;
    if (i_addr[31:SRAM_AW+2] == SRAM_BASE[31:SRAM_AW+2]) begin
      o_region = REG_SRAM;
    end else if (i_addr[31:FAB_AW+2] == FAB_BASE[31:FAB_AW+2]) begin
      o_region = REG_FAB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ibex_data_bus_bridge.sv
// ============================================================================
// Module  : ibex_data_bus_bridge
// Purpose : ibex data port -> pipelined SRAM / single-outstanding fabric window.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module ibex_data_bus_bridge
  import ibex_bridge_pkg::*;
#(
  parameter int          SRAM_AW   = 8,
  parameter logic [31:0] SRAM_BASE = 32'h0000_0000,
  parameter int          FAB_AW    = 12,
  parameter logic [31:0] FAB_BASE  = 32'h1000_0000,
  parameter int          TIMEOUT   = 16
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               data_req_i,
  output logic               data_gnt_o,
  output logic               data_rvalid_o,
  output logic               data_err_o,
  input  logic               data_we_i,
  input  logic [3:0]         data_be_i,
  input  logic [31:0]        data_addr_i,
  input  logic [31:0]        data_wdata_i,
  output logic [31:0]        data_rdata_o,
  output logic               sram_csb_o,
  output logic               sram_web_o,
  output logic [3:0]         sram_wmask_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_din_o,
  input  logic [31:0]        sram_dout_i,
  output logic               fab_req_o,
  output logic               fab_we_o,
  output logic [3:0]         fab_be_o,
  output logic [FAB_AW-1:0]  fab_addr_o,
  output logic [31:0]        fab_wdata_o,
  input  logic               fab_ack_i,
  input  logic [31:0]        fab_rdata_i
);

  localparam int             TW          = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0]  C_TIMER_END = TW'(TIMEOUT - 1);

  state_t              r_state;
  logic                r_resp_we;
  logic                r_fab_req;
  logic                r_fab_we;
  logic [3:0]          r_fab_be;
  logic [FAB_AW-1:0]   r_fab_addr;
  logic [31:0]         r_fab_wdata;
  logic [31:0]         r_fab_rdata;
  logic [TW-1:0]       r_timer;

  region_e             w_region;
  logic [SRAM_AW-1:0]  w_sram_waddr;
  logic [FAB_AW-1:0]   w_fab_waddr;
  logic                w_gnt;
  logic                w_sram_go;
  logic [31:0]         w_rdata;

  ibex_bridge_decode #(
    .SRAM_AW  (SRAM_AW),
    .SRAM_BASE(SRAM_BASE),
    .FAB_AW   (FAB_AW),
    .FAB_BASE (FAB_BASE)
  ) u_decode (
    .i_addr      (data_addr_i),
    .o_region    (w_region),
    .o_sram_waddr(w_sram_waddr),
    .o_fab_waddr (w_fab_waddr)
  );

  // Only the fabric wait blocks new grants; response states overlap the next access.
  assign w_gnt     = data_req_i & (r_state != ST_FAB_WAIT) & resetn;
  assign w_sram_go = w_gnt & (w_region == REG_SRAM);

  assign data_gnt_o   = w_gnt;
  assign sram_csb_o   = ~w_sram_go;
  assign sram_web_o   = ~(w_sram_go & data_we_i);
  assign sram_wmask_o = data_be_i;
  assign sram_addr_o  = w_sram_waddr;
  assign sram_din_o   = data_wdata_i;

  assign fab_req_o   = r_fab_req;
  assign fab_we_o    = r_fab_we;
  assign fab_be_o    = r_fab_be;
  assign fab_addr_o  = r_fab_addr;
  assign fab_wdata_o = r_fab_wdata;

  assign data_rvalid_o = resetn & ((r_state == ST_SRAM_RESP) |
                                   (r_state == ST_FAB_RESP)  |
                                   (r_state == ST_ERR_RESP));
  assign data_err_o    = resetn & (r_state == ST_ERR_RESP);
  assign data_rdata_o  = w_rdata;

  always_comb begin
    w_rdata = ERR_RDATA;
    if (resetn) begin
      if (r_state == ST_SRAM_RESP) begin
        w_rdata = r_resp_we ? 32'h0 : sram_dout_i;
      end else if (r_state == ST_FAB_RESP) begin
        w_rdata = r_fab_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_resp_we   <= 1'b0;
      r_fab_req   <= 1'b0;
      r_fab_we    <= 1'b0;
      r_fab_be    <= 4'h0;
      r_fab_addr  <= '0;
      r_fab_wdata <= 32'h0;
      r_fab_rdata <= 32'h0;
      r_timer     <= '0;
    end else if (r_state == ST_FAB_WAIT) begin
      // An ack landing on the final timeout cycle still completes normally.
      if (fab_ack_i) begin
        r_fab_req   <= 1'b0;
        r_fab_rdata <= r_fab_we ? 32'h0 : fab_rdata_i;
        r_state     <= ST_FAB_RESP;
      end else if (r_timer == C_TIMER_END) begin
        r_fab_req <= 1'b0;
        r_state   <= ST_ERR_RESP;
      end else begin
        r_timer <= r_timer + TW'(1);
      end
    end else if (w_gnt) begin
      r_resp_we <= data_we_i;
      case (w_region)
        REG_SRAM: r_state <= ST_SRAM_RESP;
        REG_FAB: begin
          r_state     <= ST_FAB_WAIT;
          r_fab_req   <= 1'b1;
          r_fab_we    <= data_we_i;
          r_fab_be    <= data_be_i;
          r_fab_addr  <= w_fab_waddr;
          r_fab_wdata <= data_wdata_i;
          r_timer     <= '0;
        end
        default: r_state <= ST_ERR_RESP;
      endcase
    end else begin
      r_state <= ST_IDLE;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ibex_data_bus_bridge.sv
// ============================================================================
// Module  : tb_ibex_data_bus_bridge
// Purpose : Randomized self-checking bench with SRAM/fabric models and a reference memory.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_ibex_data_bus_bridge;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = 4'h0;
  logic [31:0] data_addr_i = 32'h0;
  logic [31:0] data_wdata_i = 32'h0;
  logic [31:0] data_rdata_o;
  logic        sram_csb_o, sram_web_o;
  logic [3:0]  sram_wmask_o;
  logic [7:0]  sram_addr_o;
  logic [31:0] sram_din_o;
  logic [31:0] sram_dout_i;
  logic        fab_req_o, fab_we_o;
  logic [3:0]  fab_be_o;
  logic [11:0] fab_addr_o;
  logic [31:0] fab_wdata_o;
  logic        fab_ack_i = 1'b0;
  logic [31:0] fab_rdata_i = 32'h0;

  int n_checks = 0;
  int n_errors = 0;

  ibex_data_bus_bridge #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .data_req_i(data_req_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o),
    .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_rdata_o(data_rdata_o),
    .sram_csb_o(sram_csb_o), .sram_web_o(sram_web_o),
    .sram_wmask_o(sram_wmask_o), .sram_addr_o(sram_addr_o),
    .sram_din_o(sram_din_o), .sram_dout_i(sram_dout_i),
    .fab_req_o(fab_req_o), .fab_we_o(fab_we_o), .fab_be_o(fab_be_o),
    .fab_addr_o(fab_addr_o), .fab_wdata_o(fab_wdata_o),
    .fab_ack_i(fab_ack_i), .fab_rdata_i(fab_rdata_i)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_init(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0000;
  endfunction

  // SRAM macro model: registered read, byte-masked write.
  logic [31:0] sram_mem [256];
  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) sram_mem[i] <= mem_init(i);
    end else if (!sram_csb_o) begin
      if (!sram_web_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask_o[b]) sram_mem[sram_addr_o][8*b +: 8] <= sram_din_o[8*b +: 8];
      end else begin
        sram_dout_i <= sram_mem[sram_addr_o];
      end
    end
  end

  // Fabric responder: notices a request one cycle after it rises, then waits fab_delay cycles.
  int          fab_delay = -1;
  logic [31:0] fab_data  = 32'h0;
  int          fab_cnt   = 0;
  always @(posedge clk) begin
    fab_ack_i <= 1'b0;
    if (fab_req_o && !fab_ack_i && fab_delay >= 0) begin
      if (fab_cnt == fab_delay) begin
        fab_ack_i   <= 1'b1;
        fab_rdata_i <= fab_data;
      end
      fab_cnt <= fab_cnt + 1;
    end else if (!fab_req_o) begin
      fab_cnt <= 0;
    end
  end

  logic [31:0] ref_mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                     input logic [31:0] wdata, input int delay, input logic [31:0] fdata,
                     input bit hold, output logic [31:0] rd_obs);
    bit          sram_hit, fab_hit, fab_ok, last_ack;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          n, req_cyc, gnt_hi;
    sram_hit = (addr < 32'h0000_0400);
    fab_hit  = (addr >= 32'h1000_0000) && (addr < 32'h1000_4000);
    // Response arrives in request cycle delay+2; it must fit inside the TIMEOUT-cycle hold.
    fab_ok   = fab_hit && (delay >= 0) && (delay + 2 <= TIMEOUT);
    exp_err  = 1'b0;
    exp_rd   = 32'h0;
    if (sram_hit) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[addr[9:2]][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        exp_rd = ref_mem[addr[9:2]];
      end
    end else if (fab_ok) begin
      exp_rd = we ? 32'h0 : fdata;
    end else begin
      exp_err = 1'b1;
    end
    fab_delay = delay;
    fab_data  = fdata;

    @(negedge clk);
    data_req_i = 1'b1; data_we_i = we; data_be_i = be;
    data_addr_i = addr; data_wdata_i = wdata;
    #1;
    chk("gnt", {31'b0, data_gnt_o}, 32'd1);
    chk("csb", {31'b0, sram_csb_o}, sram_hit ? 32'd0 : 32'd1);
    if (sram_hit) chk("web", {31'b0, sram_web_o}, {31'b0, ~we});

    @(negedge clk);
    if (!hold) data_req_i = 1'b0;
    #1;
    if (fab_hit) begin
      chk("fab_req", {31'b0, fab_req_o}, 32'd1);
      chk("fab_addr", {20'b0, fab_addr_o}, {20'b0, addr[13:2]});
      chk("fab_we", {31'b0, fab_we_o}, {31'b0, we});
      chk("fab_be", {28'b0, fab_be_o}, {28'b0, be});
      chk("fab_wdata", fab_wdata_o, wdata);
    end
    n = 0; req_cyc = 0; gnt_hi = 0; last_ack = 1'b0;
    while (!data_rvalid_o && n < 40) begin
      if (fab_req_o) req_cyc++;
      if (data_gnt_o) gnt_hi++;
      last_ack = fab_ack_i;
      @(negedge clk); #1;
      n++;
    end
    data_req_i = 1'b0;
    rd_obs = data_rdata_o;
    chk("rvalid", {31'b0, data_rvalid_o}, 32'd1);
    chk("err", {31'b0, data_err_o}, {31'b0, exp_err});
    chk("rdata", data_rdata_o, exp_rd);
    if (fab_hit) chk("fab_req_cycles", 32'(req_cyc), fab_ok ? 32'(delay + 2) : 32'(TIMEOUT));
    if (fab_ok) chk("ack_to_rvalid", {31'b0, last_ack}, 32'd1);
    if (hold) chk("gnt_in_wait", 32'(gnt_hi), 32'd0);
    @(negedge clk); #1;
    chk("rvalid_once", {31'b0, data_rvalid_o}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, a;
    int          sel, rv;
    #200_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, a;
    int          sel, rv;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);

    // Reset state with a pending request held high.
    data_req_i = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_gnt", {31'b0, data_gnt_o}, 32'd0);
    chk("rst_csb", {31'b0, sram_csb_o}, 32'd1);
    chk("rst_web", {31'b0, sram_web_o}, 32'd1);
    chk("rst_rvalid", {31'b0, data_rvalid_o}, 32'd0);
    chk("rst_err", {31'b0, data_err_o}, 32'd0);
    chk("rst_rdata", data_rdata_o, 32'd0);
    chk("rst_fab_req", {31'b0, fab_req_o}, 32'd0);
    data_req_i = 1'b0;
    resetn = 1'b1;

    txn(1'b1, 4'hF, 32'h10, 32'hCAFE_F00D, 0, 32'h0, 1'b0, rd);
    txn(1'b0, 4'hF, 32'h10, 32'h0, 0, 32'h0, 1'b0, rd);
    chk("sram_readback", rd, 32'hCAFE_F00D);
    txn(1'b1, 4'hF, 32'h20, 32'h1122_3344, 0, 32'h0, 1'b0, rd);
    txn(1'b1, 4'b0010, 32'h20, 32'h0000_AB00, 0, 32'h0, 1'b0, rd);
    txn(1'b0, 4'hF, 32'h20, 32'h0, 0, 32'h0, 1'b0, rd);
    chk("byte_merge", rd, 32'h1122_AB44);

    // Back-to-back SRAM reads: one grant per cycle, responses one cycle behind.
    @(negedge clk);
    data_req_i = 1'b1; data_we_i = 1'b0; data_be_i = 4'hF; data_addr_i = 32'h0;
    #1;
    chk("b2b_gnt0", {31'b0, data_gnt_o}, 32'd1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      data_addr_i = 32'(4 * i);
      #1;
      chk("b2b_gnt", {31'b0, data_gnt_o}, 32'd1);
      chk("b2b_rvalid", {31'b0, data_rvalid_o}, 32'd1);
      chk("b2b_rdata", data_rdata_o, ref_mem[i-1]);
    end
    @(negedge clk);
    data_req_i = 1'b0;
    #1;
    chk("b2b_rvalid3", {31'b0, data_rvalid_o}, 32'd1);
    chk("b2b_rdata3", data_rdata_o, ref_mem[3]);
    @(negedge clk); #1;
    chk("b2b_idle", {31'b0, data_rvalid_o}, 32'd0);

    txn(1'b0, 4'hF, 32'h1000_0020, 32'h0, 1, 32'h0000_5A5A, 1'b0, rd);
    chk("fab_read", rd, 32'h0000_5A5A);
    txn(1'b0, 4'hF, 32'h1000_0024, 32'h0, -1, 32'h0, 1'b1, rd);
    txn(1'b0, 4'hF, 32'h1000_0028, 32'h0, TIMEOUT - 2, 32'h1234_5678, 1'b0, rd);
    chk("fab_ack_at_timeout", rd, 32'h1234_5678);
    txn(1'b1, 4'h3, 32'h1000_3FFC, 32'hDEAD_BEEF, 3, 32'hFFFF_FFFF, 1'b0, rd);
    txn(1'b0, 4'hF, 32'h2000_0000, 32'h0, 0, 32'h0, 1'b0, rd);
    txn(1'b0, 4'hF, 32'h0000_0400, 32'h0, 0, 32'h0, 1'b0, rd);

    for (int t = 0; t < 120; t++) begin
      sel = $urandom_range(0, 9);
      rv  = $urandom;
      if (sel < 6)      a = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      else if (sel < 9) a = 32'h1000_0000 | {18'b0, 12'($urandom), 2'b00};
      else              a = {4'($urandom_range(2, 15)), 26'($urandom), 2'b00};
      txn(1'(rv), 4'(rv >> 4), a, $urandom, $urandom_range(0, TIMEOUT), $urandom,
          1'(rv >> 8), rd);
    end

    // Reset during a fabric wait abandons the request without any response.
    fab_delay = -1;
    @(negedge clk);
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h1000_0040;
    #1;
    chk("rstw_gnt", {31'b0, data_gnt_o}, 32'd1);
    @(negedge clk);
    data_req_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rstw_req_pending", {31'b0, fab_req_o}, 32'd1);
    @(negedge clk);
    resetn = 1'b0; data_req_i = 1'b1; data_addr_i = 32'h0;
    #1;
    chk("rstw_gnt_low", {31'b0, data_gnt_o}, 32'd0);
    chk("rstw_csb", {31'b0, sram_csb_o}, 32'd1);
    @(negedge clk); #1;
    chk("rstw_fab_req", {31'b0, fab_req_o}, 32'd0);
    chk("rstw_fab_addr", {20'b0, fab_addr_o}, 32'd0);
    data_req_i = 1'b0;
    resetn = 1'b1;
    rv = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      if (data_rvalid_o || fab_req_o) rv++;
    end
    chk("rstw_no_resp", 32'(rv), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
